// File: rtl/mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mem_scheduler
// Description : Three-requester scheduler for the single core memory port.
//               Port 0 = instruction fetch, port 1 = data load/store,
//               port 2 = debug/DMA. One request is granted at a time by
//               fixed priority (1 > 2 > 0) with anti-starvation aging. It is
//               held on the memory bus until memory_ready, and completion and
//               read data are routed back to the granted port. A watchdog
//               aborts a hung access with an error pulse.
// Ports       : clk, rst (sync, active-low)
//               req_valid/addr/wdata/wstrb   packed per-port request inputs
//               req_rdata/ready/error        shared read data, per-port pulses
//               memory_valid/instr/addr/wdata/wstrb  registered memory request
//               memory_rdata/ready           memory response
// Revision    : 1.0 - initial release
// ============================================================================
module mem_scheduler #(
    parameter int MAX_WAIT = 8,     // 1..255
    parameter int TIMEOUT  = 1024   // >= 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    input  logic [95:0] req_addr,
    input  logic [95:0] req_wdata,
    input  logic [11:0] req_wstrb,
    output logic [31:0] req_rdata,
    output logic [2:0]  req_ready,
    output logic [2:0]  req_error,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    localparam int              c_AGE_W    = 8;
    localparam int              c_TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_AGE_W-1:0] c_MAX_AGE = c_AGE_W'(MAX_WAIT);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]         r_state,     w_state_nxt;
    logic [1:0]         r_grant,     w_grant_nxt;
    logic [c_TMO_W-1:0] r_tmo,       w_tmo_nxt;
    logic [c_AGE_W-1:0] r_age [3];
    logic [c_AGE_W-1:0] w_age_nxt [3];
    logic               r_mem_valid, w_mem_valid_nxt;
    logic               r_mem_instr, w_mem_instr_nxt;
    logic [31:0]        r_mem_addr,  w_mem_addr_nxt;
    logic [31:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic [3:0]         r_mem_wstrb, w_mem_wstrb_nxt;

    logic [1:0]  w_winner;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic [2:0]  w_grant_oh;
    logic        w_done;
    logic        w_tmo_hit;

    // ------------------------------------------------------------------
    // Winner selection. Aged ports override fixed priority; the loop runs
    // high-to-low so the lowest-index aged port is the last assignment.
    // ------------------------------------------------------------------
    always_comb begin
        w_winner = 2'd0;
        if (req_valid[1]) begin
            w_winner = 2'd1;
        end else if (req_valid[2]) begin
            w_winner = 2'd2;
        end
        for (int i = 2; i >= 0; i--) begin
            if (req_valid[i] && (r_age[i] == c_MAX_AGE)) begin
                w_winner = 2'(i);
            end
        end

        w_sel_addr  = 32'd0;
        w_sel_wdata = 32'd0;
        w_sel_wstrb = 4'd0;
        for (int i = 0; i < 3; i++) begin
            if (w_winner == 2'(i)) begin
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[32*i +: 32];
                w_sel_wstrb = req_wstrb[4*i +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion. memory_ready has precedence over the watchdog, so an
    // error is only flagged when the last watchdog cycle sees no ready.
    // Response pulses are suppressed while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_grant_oh[i] = (r_grant == 2'(i));
        end
        w_done    = (r_state == S_BUSY) && (memory_ready || (r_tmo == c_TMO_LAST));
        w_tmo_hit = (r_state == S_BUSY) && !memory_ready && (r_tmo == c_TMO_LAST);

        req_ready = (w_done && rst)    ? w_grant_oh : 3'b000;
        req_error = (w_tmo_hit && rst) ? w_grant_oh : 3'b000;
        req_rdata = (w_done && memory_ready && rst) ? memory_rdata : 32'd0;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_tmo_nxt       = r_tmo;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_instr_nxt = r_mem_instr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        for (int i = 0; i < 3; i++) begin
            w_age_nxt[i] = r_age[i];
        end

        case (r_state)
            S_IDLE: begin
                w_mem_valid_nxt = 1'b0;
                w_tmo_nxt       = '0;
                if (req_valid != 3'b000) begin
                    w_mem_valid_nxt = 1'b1;
                    w_mem_instr_nxt = (w_winner == 2'd0);
                    w_mem_addr_nxt  = w_sel_addr;
                    w_mem_wdata_nxt = w_sel_wdata;
                    w_mem_wstrb_nxt = w_sel_wstrb;
                    w_grant_nxt     = w_winner;
                    w_state_nxt     = S_BUSY;
                    for (int i = 0; i < 3; i++) begin
                        if (!req_valid[i] || (w_winner == 2'(i))) begin
                            w_age_nxt[i] = '0;
                        end else if (r_age[i] != c_MAX_AGE) begin
                            w_age_nxt[i] = r_age[i] + 1'b1;
                        end
                    end
                end
            end
            S_BUSY: begin
                w_tmo_nxt = r_tmo + 1'b1;
                if (w_done) begin
                    w_tmo_nxt       = '0;
                    w_mem_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_mem_valid_nxt = 1'b0;
                w_tmo_nxt       = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_grant     <= 2'd0;
            r_tmo       <= '0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_wstrb <= 4'd0;
            for (int i = 0; i < 3; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_tmo       <= w_tmo_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_instr <= w_mem_instr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            for (int i = 0; i < 3; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
        end
    end

    assign memory_valid = r_mem_valid;
    assign memory_instr = r_mem_instr;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_scheduler
// Description : Directed self-checking bench for mem_scheduler
//               (MAX_WAIT=2, TIMEOUT=16). Inputs are driven 1 ns after the
//               rising edge and outputs are sampled 4 ns after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [95:0] req_addr;
    logic [95:0] req_wdata;
    logic [11:0] req_wstrb;
    logic [31:0] req_rdata;
    logic [2:0]  req_ready;
    logic [2:0]  req_error;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    int checks;
    int errors;

    mem_scheduler #(.MAX_WAIT(2), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .req_rdata    (req_rdata),
        .req_ready    (req_ready),
        .req_error    (req_error),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point inside the current cycle.
    task automatic settle();
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc(); cyc(); settle();
        checks++; if (memory_valid !== 1'b0) begin errors++; $display("FAIL rst_mv: got %0b want 0", memory_valid); end
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_ready: got %b want 000", req_ready); end
        checks++; if (memory_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", memory_addr); end

        cyc();
        rst = 1'b1;
        req_valid = 3'b001;
        req_addr[31:0] = 32'h100;
        settle();
        checks++; if (memory_valid !== 1'b0) begin errors++; $display("FAIL arb_latency: got %0b want 0", memory_valid); end

        cyc(); settle();
        checks++; if (memory_valid !== 1'b1) begin errors++; $display("FAIL rst_busy_mv: got %0b want 1", memory_valid); end
        checks++; if (memory_addr !== 32'h100) begin errors++; $display("FAIL rst_busy_addr: got %h want 100", memory_addr); end
        checks++; if (memory_instr !== 1'b1) begin errors++; $display("FAIL rst_busy_instr: got %0b want 1", memory_instr); end
        // Assert reset mid-BUSY together with a memory response.
        rst = 1'b0;
        memory_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL rst_gate_ready: got %b want 000", req_ready); end

        cyc();
        rst = 1'b1;
        req_valid = 3'b000;
        memory_ready = 1'b0;
        settle();
        checks++; if (memory_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_mv: got %0b want 0", memory_valid); end
        checks++; if (memory_addr !== 32'h0) begin errors++; $display("FAIL rst_drop_addr: got %h want 0", memory_addr); end
        checks++; if (memory_instr !== 1'b0) begin errors++; $display("FAIL rst_drop_instr: got %0b want 0", memory_instr); end

        for (int k = 0; k < 2; k++) begin
            cyc(); settle();
            checks++; if (memory_valid !== 1'b0 || req_ready !== 3'b000) begin
                errors++; $display("FAIL rst_idle: got mv=%0b ready=%b want 0/000", memory_valid, req_ready);
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0]  exp_oh   [3];
        logic [31:0] exp_addr [3];
        exp_oh[0] = 3'b010; exp_addr[0] = 32'h1000;
        exp_oh[1] = 3'b100; exp_addr[1] = 32'h2000;
        exp_oh[2] = 3'b001; exp_addr[2] = 32'h0000;

        cyc();
        req_valid = 3'b111;
        req_addr  = {32'h2000, 32'h1000, 32'h0000};
        req_wstrb = 12'h0;
        settle();
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            checks++; if (memory_valid !== 1'b1) begin errors++; $display("FAIL prio_mv[%0d]: got %0b want 1", i, memory_valid); end
            checks++; if (memory_addr !== exp_addr[i]) begin errors++; $display("FAIL prio_addr[%0d]: got %h want %h", i, memory_addr, exp_addr[i]); end
            checks++; if (memory_instr !== (i == 2)) begin errors++; $display("FAIL prio_instr[%0d]: got %0b want %0b", i, memory_instr, (i == 2)); end
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_early[%0d]: got %b want 000", i, req_ready); end
            cyc(); settle();
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_wait[%0d]: got %b want 000", i, req_ready); end
            cyc();
            memory_ready = 1'b1;
            settle();
            checks++; if (req_ready !== exp_oh[i]) begin errors++; $display("FAIL prio_ready[%0d]: got %b want %b", i, req_ready, exp_oh[i]); end
            cyc();
            memory_ready = 1'b0;
            req_valid = req_valid & ~exp_oh[i];
            settle();
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL prio_pulse[%0d]: got %b want 000", i, req_ready); end
            checks++; if (memory_valid !== 1'b0) begin errors++; $display("FAIL prio_mvdrop[%0d]: got %0b want 0", i, memory_valid); end
        end
    endtask

    task automatic test_starvation();
        logic [31:0] exp_addr [4];
        logic [2:0]  exp_oh   [4];
        exp_addr[0] = 32'h310; exp_oh[0] = 3'b010;
        exp_addr[1] = 32'h310; exp_oh[1] = 3'b010;
        exp_addr[2] = 32'h300; exp_oh[2] = 3'b001;  // aged port 0 forced in
        exp_addr[3] = 32'h310; exp_oh[3] = 3'b010;  // port 0 age cleared again

        cyc();
        req_valid = 3'b011;
        req_addr[31:0]  = 32'h300;
        req_addr[63:32] = 32'h310;
        settle();
        for (int i = 0; i < 4; i++) begin
            cyc();
            memory_ready = 1'b1;
            settle();
            checks++; if (memory_addr !== exp_addr[i]) begin errors++; $display("FAIL starve_addr[%0d]: got %h want %h", i, memory_addr, exp_addr[i]); end
            checks++; if (req_ready !== exp_oh[i]) begin errors++; $display("FAIL starve_ready[%0d]: got %b want %b", i, req_ready, exp_oh[i]); end
            cyc();
            memory_ready = 1'b0;
            if (i == 3) req_valid = 3'b000;
            settle();
        end
    endtask

    task automatic test_read();
        cyc();
        req_valid = 3'b100;
        req_addr[95:64]  = 32'h40;
        req_wstrb[11:8]  = 4'h0;
        settle();
        cyc();
        memory_rdata = 32'hDEADBEEF;
        settle();
        checks++; if (memory_addr !== 32'h40) begin errors++; $display("FAIL rd_addr: got %h want 40", memory_addr); end
        checks++; if (memory_wstrb !== 4'h0) begin errors++; $display("FAIL rd_wstrb: got %h want 0", memory_wstrb); end
        checks++; if (memory_instr !== 1'b0) begin errors++; $display("FAIL rd_instr: got %0b want 0", memory_instr); end
        checks++; if (req_rdata !== 32'h0) begin errors++; $display("FAIL rd_idle_data: got %h want 0", req_rdata); end
        cyc();
        memory_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL rd_ready: got %b want 100", req_ready); end
        checks++; if (req_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", req_rdata); end
        checks++; if (memory_wstrb !== 4'h0) begin errors++; $display("FAIL rd_wstrb_hold: got %h want 0", memory_wstrb); end
        cyc();
        memory_ready = 1'b0;
        req_valid = 3'b000;
        settle();
        checks++; if (req_rdata !== 32'h0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL rd_after: got data=%h ready=%b want 0/000", req_rdata, req_ready);
        end
        memory_rdata = 32'h0;
    endtask

    task automatic test_timeout();
        cyc();
        req_valid = 3'b010;
        req_addr[63:32]  = 32'h500;
        req_wdata[63:32] = 32'h12345678;
        req_wstrb[7:4]   = 4'hF;
        memory_rdata     = 32'hFFFFFFFF;
        settle();
        for (int k = 1; k <= 16; k++) begin
            cyc(); settle();
            if (k == 1) begin
                checks++; if (memory_wdata !== 32'h12345678 || memory_wstrb !== 4'hF) begin
                    errors++; $display("FAIL tmo_latch: got wdata=%h wstrb=%h want 12345678/f", memory_wdata, memory_wstrb);
                end
            end
            if (k < 16) begin
                checks++; if (req_ready !== 3'b000 || req_error !== 3'b000) begin
                    errors++; $display("FAIL tmo_early[%0d]: got ready=%b err=%b want 000/000", k, req_ready, req_error);
                end
            end else begin
                checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL tmo_ready: got %b want 010", req_ready); end
                checks++; if (req_error !== 3'b010) begin errors++; $display("FAIL tmo_error: got %b want 010", req_error); end
                checks++; if (req_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 0", req_rdata); end
            end
        end
        cyc();
        req_valid = 3'b001;
        req_addr[31:0] = 32'h600;
        settle();
        checks++; if (memory_valid !== 1'b0 || req_error !== 3'b000) begin
            errors++; $display("FAIL tmo_drop: got mv=%0b err=%b want 0/000", memory_valid, req_error);
        end
        cyc();
        memory_ready = 1'b1;
        settle();
        checks++; if (memory_addr !== 32'h600 || memory_instr !== 1'b1) begin
            errors++; $display("FAIL tmo_next: got addr=%h instr=%0b want 600/1", memory_addr, memory_instr);
        end
        checks++; if (req_ready !== 3'b001 || req_error !== 3'b000) begin
            errors++; $display("FAIL tmo_next_ready: got ready=%b err=%b want 001/000", req_ready, req_error);
        end
        cyc();
        memory_ready = 1'b0;
        req_valid = 3'b000;
        memory_rdata = 32'h0;
        settle();
    endtask

    task automatic test_edges();
        // memory_ready on the same cycle as the last watchdog cycle
        cyc();
        req_valid = 3'b010;
        req_addr[63:32] = 32'h700;
        settle();
        for (int k = 1; k <= 16; k++) begin
            cyc();
            if (k == 16) begin
                memory_ready = 1'b1;
                memory_rdata = 32'hCAFEF00D;
            end
            settle();
        end
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL edge_tie_ready: got %b want 010", req_ready); end
        checks++; if (req_error !== 3'b000) begin errors++; $display("FAIL edge_tie_error: got %b want 000", req_error); end
        checks++; if (req_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL edge_tie_data: got %h want cafef00d", req_rdata); end

        // spurious memory_ready while idle
        cyc();
        req_valid = 3'b000;
        memory_ready = 1'b0;
        settle();
        cyc();
        memory_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 3'b000 || req_rdata !== 32'h0 || memory_valid !== 1'b0) begin
            errors++; $display("FAIL edge_spurious: got ready=%b data=%h mv=%0b want 000/0/0", req_ready, req_rdata, memory_valid);
        end

        // port 1 drops valid while its access is in flight
        cyc();
        memory_ready = 1'b0;
        memory_rdata = 32'h0;
        req_valid = 3'b010;
        req_addr[63:32] = 32'h800;
        settle();
        cyc();
        req_valid = 3'b000;
        settle();
        checks++; if (memory_valid !== 1'b1 || memory_addr !== 32'h800) begin
            errors++; $display("FAIL edge_drop_busy: got mv=%0b addr=%h want 1/800", memory_valid, memory_addr);
        end
        cyc(); settle();
        checks++; if (memory_valid !== 1'b1) begin errors++; $display("FAIL edge_drop_hold: got %0b want 1", memory_valid); end
        cyc();
        memory_ready = 1'b1;
        settle();
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL edge_drop_ready: got %b want 010", req_ready); end
        cyc();
        memory_ready = 1'b0;
        settle();
        checks++; if (memory_valid !== 1'b0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL edge_drop_after: got mv=%0b ready=%b want 0/000", memory_valid, req_ready);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b0;
        req_valid    = 3'b000;
        req_addr     = 96'h0;
        req_wdata    = 96'h0;
        req_wstrb    = 12'h0;
        memory_rdata = 32'h0;
        memory_ready = 1'b0;

        test_reset();
        test_priority();
        test_starvation();
        test_read();
        test_timeout();
        test_edges();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
